cl_pipe: RTL and testbench

Parametrised, registered successor to the 1-bit logic cell. It computes XOR/AND/OR/NOT over WIDTH-bit operands, selected by a 2-bit op code, and delivers the result through a one-stage valid/ready pipeline register. It adds an accumulator mode, in which operand A is replaced by an internal register, plus a zero flag and a saturating operation counter. It sits between operand sources and downstream consumers in the datapath labs.

---
 rtl/cl_pkg.sv | 14 +
 rtl/cl_pipe_if.sv | 35 +++
 rtl/cl_vec.sv | 25 ++
 rtl/cl_pipe.sv | 82 ++++++++
 tb/tb_cl_pipe.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cl_pkg.sv
// Shared definitions for the cl_pipe logic-cell datapath: op encodings and default sizes.
package cl_pkg;

    localparam int CL_WIDTH = 8;
    localparam int CL_CNT_W = 16;

    typedef enum logic [1:0] {
        OP_XOR = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_NOT = 2'b11
    } cl_op_e;

endpackage : cl_pkg

// File: rtl/cl_pipe_if.sv
// Operand/result bundle for cl_pipe. The master side is the operand source plus the result consumer;
// the slave side is the pipe itself.
interface cl_pipe_if
    import cl_pkg::*;
#(
    parameter int WIDTH = CL_WIDTH,
    parameter int CNT_W = CL_CNT_W
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       s;
    logic             acc_mode;
    logic             acc_load;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, a, b, s, acc_mode, acc_load, acc_clr, out_ready,
        input  in_ready, out_valid, result, zero, acc, op_count
    );

    modport slave (
        input  in_valid, a, b, s, acc_mode, acc_load, acc_clr, out_ready,
        output in_ready, out_valid, result, zero, acc, op_count
    );

endinterface : cl_pipe_if

// File: rtl/cl_vec.sv
// Combinational WIDTH-bit logic function: XOR / AND / OR / NOT of x, chosen by s.
module cl_vec
    import cl_pkg::*;
#(
    parameter int WIDTH = CL_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] r
);

    // Bitwise op selection; NOT ignores b.
    always_comb begin
        r = '0;
        case (cl_op_e'(s))
            OP_XOR:  r = x ^ b;
            OP_AND:  r = x & b;
            OP_OR:   r = x | b;
            OP_NOT:  r = ~x;
            default: r = '0;
        endcase
    end

endmodule : cl_vec

// File: rtl/cl_pipe.sv
// Registered logic cell: one-stage valid/ready result register, accumulator operand mode,
// zero flag and a saturating count of accepted operations.
module cl_pipe
    import cl_pkg::*;
#(
    parameter int WIDTH = CL_WIDTH,
    parameter int CNT_W = CL_CNT_W
) (
    input logic        clk,
    input logic        reset_n,
    cl_pipe_if.slave   bus
);

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] op_count_q;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] r;

    // The slot is free when empty or when its current content drains this cycle.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign x        = bus.acc_mode ? acc_q : bus.a;

    cl_vec #(.WIDTH(WIDTH)) u_vec (
        .x (x),
        .b (bus.b),
        .s (bus.s),
        .r (r)
    );

    // Result register and its valid flag; a drain and a new accept on the same edge leave no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            result_q    <= r;
            zero_q      <= (r == '0);
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Accumulator: clear beats load beats write-back, independent of the handshake.
    // The emitted result always uses the pre-edge accumulator value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (bus.acc_clr) begin
            acc_q <= '0;
        end else if (bus.acc_load) begin
            acc_q <= bus.b;
        end else if (accept && bus.acc_mode) begin
            acc_q <= r;
        end
    end

    // Accepted-operation counter, sticks at all-ones until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_count_q <= '0;
        end else if (accept && (op_count_q != {CNT_W{1'b1}})) begin
            op_count_q <= op_count_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.acc       = acc_q;
    assign bus.op_count  = op_count_q;

endmodule : cl_pipe

// File: tb/tb_cl_pipe.sv
// Directed bench for cl_pipe: one 8-bit/16-bit-counter instance for the datapath,
// plus a 2-bit-counter instance for saturation and mid-stream reset.
module tb_cl_pipe;

    logic clk;
    logic reset_n;

    int n_tests;
    int n_fail;

    cl_pipe_if #(.WIDTH(8), .CNT_W(16)) bus1 ();
    cl_pipe_if #(.WIDTH(8), .CNT_W(2))  bus2 ();

    cl_pipe #(.WIDTH(8), .CNT_W(16)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    cl_pipe #(.WIDTH(8), .CNT_W(2)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                          input logic ordy);
        bus1.in_valid  = v;
        bus1.a         = a;
        bus1.b         = b;
        bus1.s         = s;
        bus1.out_ready = ordy;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        drive1(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
        bus1.acc_mode = 1'b0;
        bus1.acc_load = 1'b0;
        bus1.acc_clr  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.a         = 8'h00;
        bus2.b         = 8'h00;
        bus2.s         = 2'b00;
        bus2.out_ready = 1'b1;
        bus2.acc_mode  = 1'b0;
        bus2.acc_load  = 1'b0;
        bus2.acc_clr   = 1'b0;

        #2;
        chk("rst_result", 32'(bus1.result), 32'h00);
        chk("rst_zero", 32'(bus1.zero), 32'h0);
        chk("rst_out_valid", 32'(bus1.out_valid), 32'h0);
        chk("rst_acc", 32'(bus1.acc), 32'h00);
        chk("rst_op_count", 32'(bus1.op_count), 32'h0);
        chk("rst_in_ready", 32'(bus1.in_ready), 32'h1);

        #10;
        reset_n = 1'b1;
        tick();

        // Four ops back to back on F0 / 3C
        drive1(1'b1, 8'hF0, 8'h3C, 2'b00, 1'b1);
        tick();
        chk("xor_result", 32'(bus1.result), 32'hCC);
        chk("xor_valid", 32'(bus1.out_valid), 32'h1);
        drive1(1'b1, 8'hF0, 8'h3C, 2'b01, 1'b1);
        tick();
        chk("and_result", 32'(bus1.result), 32'h30);
        chk("and_valid", 32'(bus1.out_valid), 32'h1);
        drive1(1'b1, 8'hF0, 8'h3C, 2'b10, 1'b1);
        tick();
        chk("or_result", 32'(bus1.result), 32'hFC);
        drive1(1'b1, 8'hF0, 8'h3C, 2'b11, 1'b1);
        tick();
        chk("not_result", 32'(bus1.result), 32'h0F);
        chk("not_valid", 32'(bus1.out_valid), 32'h1);
        chk("count_4", 32'(bus1.op_count), 32'd4);

        // Zero flag
        drive1(1'b1, 8'hAA, 8'hAA, 2'b00, 1'b1);
        tick();
        chk("zero_result", 32'(bus1.result), 32'h00);
        chk("zero_set", 32'(bus1.zero), 32'h1);
        drive1(1'b1, 8'h01, 8'h00, 2'b10, 1'b1);
        tick();
        chk("nonzero_result", 32'(bus1.result), 32'h01);
        chk("zero_clr", 32'(bus1.zero), 32'h0);

        // Backpressure
        drive1(1'b1, 8'h12, 8'h34, 2'b00, 1'b1);
        tick();
        chk("bp_first", 32'(bus1.result), 32'h26);
        chk("count_7", 32'(bus1.op_count), 32'd7);
        drive1(1'b1, 8'hFF, 8'h00, 2'b00, 1'b0);
        #1;
        chk("bp_in_ready_low", 32'(bus1.in_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_result", 32'(bus1.result), 32'h26);
            chk("bp_hold_valid", 32'(bus1.out_valid), 32'h1);
            chk("bp_hold_ready", 32'(bus1.in_ready), 32'h0);
            chk("bp_hold_count", 32'(bus1.op_count), 32'd7);
        end
        bus1.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus1.in_ready), 32'h1);
        tick();
        chk("bp_release_result", 32'(bus1.result), 32'hFF);
        chk("bp_release_valid", 32'(bus1.out_valid), 32'h1);
        chk("count_8", 32'(bus1.op_count), 32'd8);

        // Drain with no new op: valid drops, result held
        drive1(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
        tick();
        chk("drain_valid", 32'(bus1.out_valid), 32'h0);
        chk("drain_result", 32'(bus1.result), 32'hFF);

        // Accumulator
        bus1.acc_load = 1'b1;
        drive1(1'b0, 8'h00, 8'h0F, 2'b00, 1'b1);
        tick();
        chk("acc_load", 32'(bus1.acc), 32'h0F);
        chk("acc_load_count", 32'(bus1.op_count), 32'd8);
        bus1.acc_load = 1'b0;
        bus1.acc_mode = 1'b1;
        drive1(1'b1, 8'h11, 8'hF0, 2'b10, 1'b1);
        tick();
        chk("acc_or_result", 32'(bus1.result), 32'hFF);
        chk("acc_or_acc", 32'(bus1.acc), 32'hFF);
        drive1(1'b1, 8'h11, 8'hF0, 2'b11, 1'b1);
        tick();
        chk("acc_not_result", 32'(bus1.result), 32'h00);
        chk("acc_not_acc", 32'(bus1.acc), 32'h00);
        chk("acc_not_zero", 32'(bus1.zero), 32'h1);

        // Priority: clear over load over write-back; result uses pre-edge acc
        bus1.acc_mode = 1'b0;
        bus1.acc_load = 1'b1;
        drive1(1'b0, 8'h00, 8'h55, 2'b00, 1'b1);
        tick();
        chk("prio_preload", 32'(bus1.acc), 32'h55);
        bus1.acc_mode = 1'b1;
        bus1.acc_clr  = 1'b1;
        bus1.acc_load = 1'b1;
        drive1(1'b1, 8'h00, 8'h33, 2'b11, 1'b1);
        tick();
        chk("prio_clr_result", 32'(bus1.result), 32'hAA);
        chk("prio_clr_acc", 32'(bus1.acc), 32'h00);
        bus1.acc_clr = 1'b0;
        drive1(1'b1, 8'h00, 8'h33, 2'b01, 1'b1);
        tick();
        chk("prio_load_result", 32'(bus1.result), 32'h00);
        chk("prio_load_acc", 32'(bus1.acc), 32'h33);
        chk("count_12", 32'(bus1.op_count), 32'd12);
        bus1.acc_load = 1'b0;
        bus1.acc_mode = 1'b0;
        drive1(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);

        // Saturating 2-bit counter on the second instance
        bus2.in_valid = 1'b1;
        bus2.a        = 8'h01;
        bus2.b        = 8'h5A;
        bus2.s        = 2'b10;
        bus2.acc_load = 1'b1;
        tick();
        chk("sat_count_1", 32'(bus2.op_count), 32'd1);
        chk("sat_result", 32'(bus2.result), 32'h5B);
        bus2.acc_load = 1'b0;
        tick();
        chk("sat_count_2", 32'(bus2.op_count), 32'd2);
        tick();
        chk("sat_count_3", 32'(bus2.op_count), 32'd3);
        tick();
        chk("sat_count_hold4", 32'(bus2.op_count), 32'd3);
        tick();
        chk("sat_count_hold5", 32'(bus2.op_count), 32'd3);
        chk("sat_acc", 32'(bus2.acc), 32'h5A);
        chk("sat_valid", 32'(bus2.out_valid), 32'h1);

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus2.out_valid), 32'h0);
        chk("arst_acc", 32'(bus2.acc), 32'h00);
        chk("arst_count", 32'(bus2.op_count), 32'd0);
        chk("arst_result", 32'(bus2.result), 32'h00);
        chk("arst_dut1_acc", 32'(bus1.acc), 32'h00);
        chk("arst_dut1_count", 32'(bus1.op_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cl_pipe
